// File: rtl/sub8_rr_arbiter_pkg.sv
// Shared types, saturation limits and the round-robin grant helper
// for the sub8_rr_arbiter block.
package sub8_arb_pkg;

  localparam int PTRW = 3;

  localparam logic [7:0] SAT_MAX = 8'sd127;
  localparam logic [7:0] SAT_MIN = -8'sd128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic            found;
    logic [PTRW-1:0] idx;
  } grant_t;

  // First set bit of valid at or after ptr, wrapping modulo nreq (nreq <= 8).
  function automatic grant_t rr_next_grant(input logic [PTRW-1:0] ptr,
                                           input logic [7:0]      valid,
                                           input logic [3:0]      nreq);
    grant_t     g;
    logic [3:0] pos;
    g = '0;
    for (int k = 0; k < 8; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= nreq) begin
        pos = pos - nreq;
      end else begin
        pos = pos;
      end
      if ((4'(k) < nreq) && !g.found && valid[pos[2:0]]) begin
        g.found = 1'b1;
        g.idx   = pos[2:0];
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sub_8bit_signed.sv
// 8-bit signed subtractor built as A + (~B + 1); the overflow flag is the
// two's-complement overflow of that addition.
module sub_8bit_signed (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] result,
  output logic       overflow
);

  logic [7:0] b_neg_s;

  // Negate B, add, and flag a sign change between like-signed operands.
  always_comb begin
    b_neg_s  = ~B + 8'd1;
    result   = A + b_neg_s;
    overflow = (A[7] == b_neg_s[7]) && (result[7] != A[7]);
  end

endmodule

// File: rtl/sub8_rr_arbiter.sv
// Round-robin sharing of one signed 8-bit subtractor among NREQ requesters,
// with a one-deep registered response channel and an overflow event counter.
module sub8_rr_arbiter
  import sub8_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int SATURATE = 0,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_result,
  output logic                rsp_overflow,
  output logic [CNTW-1:0]     ovf_count,
  input  logic                ovf_clear
);

  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_result_q, rsp_result_d;
  logic            rsp_overflow_q, rsp_overflow_d;
  logic [CNTW-1:0] ovf_count_q, ovf_count_d;

  grant_t          grant_s;
  logic            can_accept_s;
  logic            transfer_s;
  logic [NREQ-1:0] grant_oh_s;
  logic [7:0]      a_s, b_s;
  logic [7:0]      dp_result_s;
  logic            dp_ovf_s;
  logic [7:0]      result_s;

  // Arbitration: a slot is free when empty or when the held result leaves now.
  always_comb begin
    can_accept_s = (state_q == EMPTY) || rsp_ready;
    grant_s      = rr_next_grant(ptr_q, 8'(req_valid), 4'(NREQ));
    transfer_s   = can_accept_s && grant_s.found;
    if (transfer_s) begin
      grant_oh_s = NREQ'(1'b1) << grant_s.idx;
    end else begin
      grant_oh_s = '0;
    end
  end

  assign req_ready = grant_oh_s;

  // Operand mux driven by the granted index.
  always_comb begin
    a_s = 8'd0;
    b_s = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      a_s = (grant_s.idx == PTRW'(i)) ? req_a[8*i +: 8] : a_s;
      b_s = (grant_s.idx == PTRW'(i)) ? req_b[8*i +: 8] : b_s;
    end
  end

  sub_8bit_signed u_sub (
    .A        (a_s),
    .B        (b_s),
    .result   (dp_result_s),
    .overflow (dp_ovf_s)
  );

  // Optional clamp toward the sign of the minuend on overflow.
  always_comb begin
    if ((SATURATE != 0) && dp_ovf_s) begin
      result_s = a_s[7] ? SAT_MIN : SAT_MAX;
    end else begin
      result_s = dp_result_s;
    end
  end

  // Next-state for FSM, pointer, response register and counter.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    ovf_count_d    = ovf_count_q;

    case (state_q)
      EMPTY: begin
        if (transfer_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rsp_ready && !transfer_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (transfer_s) begin
      ptr_d          = (grant_s.idx == LAST_IDX) ? '0 : grant_s.idx + 3'd1;
      rsp_id_d       = grant_s.idx[IDW-1:0];
      rsp_result_d   = result_s;
      rsp_overflow_d = dp_ovf_s;
    end else begin
      ptr_d = ptr_q;
    end

    // Clear has priority over a same-cycle increment.
    if (ovf_clear) begin
      ovf_count_d = '0;
    end else if (transfer_s && dp_ovf_s && (ovf_count_q != {CNTW{1'b1}})) begin
      ovf_count_d = ovf_count_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // State, pointer, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      ptr_q          <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= 8'd0;
      rsp_overflow_q <= 1'b0;
      ovf_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      ovf_count_q    <= ovf_count_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_sub8_rr_arbiter.sv
// Vector table plus scoreboard bench for sub8_rr_arbiter; a second instance
// with SATURATE=1 sees the same stimulus and is checked on its result only.
module tb_sub8_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready, req_ready_sat;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_valid_sat;
  logic        rsp_ready;
  logic [1:0]  rsp_id, rsp_id_sat;
  logic [7:0]  rsp_result, rsp_result_sat;
  logic        rsp_overflow, rsp_overflow_sat;
  logic [15:0] ovf_count, ovf_count_sat;
  logic        ovf_clear;

  sub8_rr_arbiter #(.NREQ(4), .IDW(2), .SATURATE(0), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  sub8_rr_arbiter #(.NREQ(4), .IDW(2), .SATURATE(1), .CNTW(16)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_sat),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_sat), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_sat), .rsp_result(rsp_result_sat), .rsp_overflow(rsp_overflow_sat),
    .ovf_count(ovf_count_sat), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       rr;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic [7:0] res_sat;
    logic       ovf;
  } rsp_t;

  rsp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cnt_m    = 0;
  vec_t   vecs[23];
  vec_t   vr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: A-B with the flag defined via A + (-B).
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input bit sat);
    int         sa, sb, diff;
    logic       ovf;
    logic [7:0] res;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    diff = sa - sb;
    if (sb == -128) ovf = (sa < 0);
    else            ovf = (diff > 127) || (diff < -128);
    res = 8'(diff);
    if (sat && ovf) res = (sa < 0) ? 8'h80 : 8'h7F;
    return {ovf, res};
  endfunction

  // Drive one cycle of stimulus, check at the falling edge, update scoreboard.
  task automatic step(input vec_t v);
    int         g;
    logic [7:0] la;
    logic [8:0] w, s;
    rsp_t       it;
    req_valid = v.valid;
    rsp_ready = v.rr;
    ovf_clear = v.clr;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = v.a + 8'(i);
      req_b[8*i +: 8] = v.b;
    end
    #4;
    chk("req_ready", int'(req_ready), int'(v.exp_ready));
    chk("rsp_valid", int'(rsp_valid), (sb_q.size() != 0) ? 1 : 0);
    chk("ovf_count", int'(ovf_count), cnt_m);
    if (sb_q.size() != 0) begin
      chk("rsp_id", int'(rsp_id), int'(sb_q[0].id));
      chk("rsp_result", int'(rsp_result), int'(sb_q[0].res));
      chk("rsp_overflow", int'(rsp_overflow), int'(sb_q[0].ovf));
      chk("rsp_result_sat", int'(rsp_result_sat), int'(sb_q[0].res_sat));
      if (v.rr) void'(sb_q.pop_front());
    end
    g = -1;
    for (int i = 3; i >= 0; i--) if (v.exp_ready[i]) g = i;
    if (g >= 0) begin
      la = v.a + 8'(g);
      w  = ref_sub(la, v.b, 1'b0);
      s  = ref_sub(la, v.b, 1'b1);
      it.id = 2'(g); it.res = w[7:0]; it.ovf = w[8]; it.res_sat = s[7:0];
      sb_q.push_back(it);
    end
    if (v.clr) cnt_m = 0;
    else if ((g >= 0) && w[8]) cnt_m = cnt_m + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'h0; rsp_ready = 1'b0; ovf_clear = 1'b0;
    req_a = 32'h0; req_b = 32'h0;

    //            valid  rr    a      b      clr   exp_ready
    vecs[0]  = '{4'hF, 1'b1, 8'd10, 8'd3,  1'b0, 4'h1};
    vecs[1]  = '{4'hF, 1'b1, 8'd10, 8'd3,  1'b0, 4'h2};
    vecs[2]  = '{4'hF, 1'b1, 8'd10, 8'd3,  1'b0, 4'h4};
    vecs[3]  = '{4'hF, 1'b1, 8'd10, 8'd3,  1'b0, 4'h8};
    vecs[4]  = '{4'hF, 1'b1, 8'd10, 8'd3,  1'b0, 4'h1};
    vecs[5]  = '{4'h1, 1'b1, 8'd5,  8'd3,  1'b0, 4'h1};
    vecs[6]  = '{4'h0, 1'b1, 8'd0,  8'd0,  1'b0, 4'h0};
    vecs[7]  = '{4'h3, 1'b1, 8'd20, 8'd7,  1'b0, 4'h2};
    vecs[8]  = '{4'h3, 1'b0, 8'd20, 8'd7,  1'b0, 4'h0};
    vecs[9]  = '{4'h3, 1'b0, 8'd20, 8'd7,  1'b0, 4'h0};
    vecs[10] = '{4'h3, 1'b0, 8'd20, 8'd7,  1'b0, 4'h0};
    vecs[11] = '{4'h3, 1'b0, 8'd20, 8'd7,  1'b0, 4'h0};
    vecs[12] = '{4'h3, 1'b0, 8'd20, 8'd7,  1'b0, 4'h0};
    vecs[13] = '{4'h3, 1'b1, 8'd20, 8'd7,  1'b0, 4'h1};
    vecs[14] = '{4'h0, 1'b1, 8'd0,  8'd0,  1'b0, 4'h0};
    vecs[15] = '{4'h1, 1'b1, 8'h7F, 8'hFF, 1'b0, 4'h1};
    vecs[16] = '{4'h1, 1'b1, 8'h80, 8'h01, 1'b0, 4'h1};
    vecs[17] = '{4'h1, 1'b1, 8'h00, 8'h80, 1'b0, 4'h1};
    vecs[18] = '{4'h1, 1'b1, 8'hFF, 8'h80, 1'b0, 4'h1};
    vecs[19] = '{4'h1, 1'b1, 8'h40, 8'hC0, 1'b0, 4'h1};
    vecs[20] = '{4'h0, 1'b1, 8'd0,  8'd0,  1'b0, 4'h0};
    vecs[21] = '{4'h1, 1'b1, 8'h7F, 8'hFF, 1'b1, 4'h1};
    vecs[22] = '{4'h0, 1'b1, 8'd0,  8'd0,  1'b0, 4'h0};

    #3;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_result", int'(rsp_result), 0);
    chk("reset_rsp_overflow", int'(rsp_overflow), 0);
    chk("reset_ovf_count", int'(ovf_count), 0);
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 23; n++) step(vecs[n]);
    chk("ovf_count_after_clear", int'(ovf_count), 0);

    // Hold an overflowed result, then reset asynchronously mid-cycle.
    vr = '{4'h1, 1'b0, 8'h7F, 8'hFF, 1'b0, 4'h1};
    step(vr);
    vr = '{4'h0, 1'b0, 8'd0, 8'd0, 1'b0, 4'h0};
    step(vr);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", int'(rsp_valid), 0);
    chk("async_rst_rsp_valid_sat", int'(rsp_valid_sat), 0);
    chk("async_rst_rsp_result", int'(rsp_result), 0);
    chk("async_rst_ovf_count", int'(ovf_count), 0);
    sb_q.delete();
    cnt_m = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vr = '{4'hF, 1'b1, 8'd1, 8'd1, 1'b0, 4'h1};
    step(vr);
    vr = '{4'hF, 1'b1, 8'd1, 8'd1, 1'b0, 4'h2};
    step(vr);
    vr = '{4'h0, 1'b1, 8'd0, 8'd0, 1'b0, 4'h0};
    step(vr);
    step(vr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
